// File: rtl/host_io_bridge.sv
// Host-side bridge: streams matrix bytes into weight memory and serializes MMU results back to the host.
// Optional CHECKSUM_EN macro appends one XOR checksum byte after the result bytes.
module host_io_bridge #(
    parameter int DATA_W  = 8,
    parameter int N_ELEMS = 8,
    parameter int N_RES   = 4,
    parameter int RES_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req_mat,
    input  logic              host_mat_wb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] mat_data,
    output logic              mat_valid,
    output logic [2:0]        mat_idx,
    output logic              load_done,
    input  logic [RES_W-1:0]  res_data,
    input  logic              res_valid,
    output logic              res_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_done
);
    localparam int BPR    = RES_W / DATA_W;
    localparam int ELEM_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam int RIDX_W = (N_RES > 1) ? $clog2(N_RES) : 1;
    localparam int BSEL_W = (BPR > 1) ? $clog2(BPR) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_SEND
`ifdef CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [RIDX_W-1:0]   res_cnt_q, res_cnt_d;
    logic [RIDX_W-1:0]   res_sel_q, res_sel_d;
    logic [BSEL_W-1:0]   byte_sel_q, byte_sel_d;
    logic [RES_W-1:0]    res_buf_q [N_RES];
    logic [RES_W-1:0]    res_buf_d [N_RES];
    logic [DATA_W-1:0]   mat_data_q, mat_data_d;
    logic                mat_valid_q, mat_valid_d;
    logic [2:0]          mat_idx_q, mat_idx_d;
    logic                load_done_q, load_done_d;
    logic                wb_done_q, wb_done_d;
    logic [DATA_W-1:0]   out_byte;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    assign mat_data  = mat_data_q;
    assign mat_valid = mat_valid_q;
    assign mat_idx   = mat_idx_q;
    assign load_done = load_done_q;
    assign wb_done   = wb_done_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        res_cnt_d   = res_cnt_q;
        res_sel_d   = res_sel_q;
        byte_sel_d  = byte_sel_q;
        res_buf_d   = res_buf_q;
        mat_data_d  = mat_data_q;
        mat_valid_d = 1'b0;
        mat_idx_d   = mat_idx_q;
        load_done_d = 1'b0;
        wb_done_d   = 1'b0;
        in_ready    = 1'b0;
        res_ready   = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
`ifdef CHECKSUM_EN
        csum_d      = csum_q;
`endif
        // Low byte of each result goes out first.
        out_byte = DATA_W'(res_buf_q[res_sel_q] >> (DATA_W * int'(byte_sel_q)));

        case (state_q)
            S_IDLE: begin
                if (host_req_mat)     state_d = S_LOAD;
                else if (host_mat_wb) state_d = S_CAPTURE;
            end
            S_LOAD: begin
                in_ready = host_req_mat;
                if (!host_req_mat) begin
                    elem_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (in_valid) begin
                    mat_data_d  = in_data;
                    mat_valid_d = 1'b1;
                    mat_idx_d   = 3'(elem_cnt_q);
                    if (elem_cnt_q == ELEM_W'(N_ELEMS - 1)) begin
                        load_done_d = 1'b1;
                        elem_cnt_d  = '0;
                        state_d     = S_IDLE;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                res_ready = host_mat_wb;
                if (!host_mat_wb) begin
                    res_cnt_d = '0;
                    state_d   = S_IDLE;
                end else if (res_valid) begin
                    res_buf_d[res_cnt_q] = res_data;
                    if (res_cnt_q == RIDX_W'(N_RES - 1)) begin
                        res_cnt_d  = '0;
                        res_sel_d  = '0;
                        byte_sel_d = '0;
`ifdef CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = S_SEND;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = out_byte;
                if (out_ready) begin
`ifdef CHECKSUM_EN
                    csum_d = csum_q ^ out_byte;
`endif
                    if (byte_sel_q == BSEL_W'(BPR - 1)) begin
                        byte_sel_d = '0;
                        if (res_sel_q == RIDX_W'(N_RES - 1)) begin
                            res_sel_d = '0;
`ifdef CHECKSUM_EN
                            state_d   = S_CSUM;
`else
                            wb_done_d = 1'b1;
                            state_d   = S_IDLE;
`endif
                        end else begin
                            res_sel_d = res_sel_q + 1'b1;
                        end
                    end else begin
                        byte_sel_d = byte_sel_q + 1'b1;
                    end
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                if (out_ready) begin
                    csum_d    = '0;
                    wb_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_cnt_q  <= '0;
            res_cnt_q   <= '0;
            res_sel_q   <= '0;
            byte_sel_q  <= '0;
            mat_data_q  <= '0;
            mat_valid_q <= 1'b0;
            mat_idx_q   <= '0;
            load_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            res_cnt_q   <= res_cnt_d;
            res_sel_q   <= res_sel_d;
            byte_sel_q  <= byte_sel_d;
            mat_data_q  <= mat_data_d;
            mat_valid_q <= mat_valid_d;
            mat_idx_q   <= mat_idx_d;
            load_done_q <= load_done_d;
            wb_done_q   <= wb_done_d;
`ifdef CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // NOTE: the result buffer is data storage only; it is always rewritten before SEND, so it needs no reset.
    always_ff @(posedge clk) begin
        res_buf_q <= res_buf_d;
    end

endmodule

// File: tb/tb_host_io_bridge.sv
// Self-checking bench for host_io_bridge: randomized loads/writebacks checked against a byte-level model.
// Build with +define+CHECKSUM_EN to also expect the trailing XOR byte.
module tb_host_io_bridge;
    localparam int DATA_W  = 8;
    localparam int N_ELEMS = 8;
    localparam int N_RES   = 4;
    localparam int RES_W   = 16;
    localparam int BPR     = RES_W / DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_req_mat = 1'b0;
    logic              host_mat_wb = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] mat_data;
    logic              mat_valid;
    logic [2:0]        mat_idx;
    logic              load_done;
    logic [RES_W-1:0]  res_data = '0;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              wb_done;

    int tests = 0;
    int fails = 0;

    // Observed traffic, collected on the falling edge.
    logic [11:0]       mat_q [$];
    logic [DATA_W-1:0] out_q [$];
    int                ld_cnt = 0;
    int                wb_cnt = 0;

    host_io_bridge #(
        .DATA_W(DATA_W), .N_ELEMS(N_ELEMS), .N_RES(N_RES), .RES_W(RES_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req_mat(host_req_mat), .host_mat_wb(host_mat_wb),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mat_data(mat_data), .mat_valid(mat_valid), .mat_idx(mat_idx), .load_done(load_done),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mat_valid) mat_q.push_back({load_done, mat_idx, mat_data});
        if (load_done) ld_cnt++;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (wb_done) wb_cnt++;
    end

    task automatic drive_load(input logic [7:0] bytes [8], input int stop, input bit hold, input bit drop);
        int got = 0;
        int guard = 0;
        host_req_mat = 1'b1;
        while (got < stop && guard < 200) begin
            in_valid = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            in_data  = bytes[got];
            #1;
            if (in_valid && in_ready) got++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (drop) host_req_mat = 1'b0;
        tests++;
        if (guard >= 200) begin
            fails++;
            $display("FAIL load_timeout: accepted %0d, required %0d", got, stop);
        end
    endtask

    task automatic check_load(input logic [7:0] bytes [8], input int stop, input bit hold, input string name);
        int start = mat_q.size();
        int ld0 = ld_cnt;
        int n;
        logic [11:0] exp;
        drive_load(bytes, stop, hold, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n = mat_q.size() - start;
        tests++;
        if (n != stop) begin
            fails++;
            $display("FAIL %s count: got %0d strobes, required %0d", name, n, stop);
        end
        for (int i = 0; i < stop && i < n; i++) begin
            exp = {1'(stop == N_ELEMS && i == N_ELEMS - 1), 3'(i), bytes[i]};
            tests++;
            if (mat_q[start + i] !== exp) begin
                fails++;
                $display("FAIL %s beat%0d: got {done,idx,data}=%h, required %h", name, i, mat_q[start + i], exp);
            end
        end
        tests++;
        if (ld_cnt - ld0 != ((stop == N_ELEMS) ? 1 : 0)) begin
            fails++;
            $display("FAIL %s load_done: got %0d pulses, required %0d", name, ld_cnt - ld0, (stop == N_ELEMS) ? 1 : 0);
        end
    endtask

    task automatic check_wb(input logic [15:0] res [4], input int stop, input int mode, input bit rv, input string name);
        int got = 0;
        int guard = 0;
        int start = out_q.size();
        int wb0 = wb_cnt;
        bit tog = 1'b1;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic [7:0] exp_q [$];
        logic [7:0] cs = '0;
        logic [7:0] b;

        host_mat_wb = 1'b1;
        while (got < stop && guard < 200) begin
            res_valid = rv ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            res_data  = res[got];
            #1;
            if (res_valid && res_ready) got++;
            @(posedge clk); #1;
            guard++;
        end
        res_valid = 1'b0;
        tests++;
        if (guard >= 200) begin
            fails++;
            $display("FAIL %s capture_timeout: accepted %0d, required %0d", name, got, stop);
        end

        if (stop < N_RES) begin
            host_mat_wb = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            tests++;
            if (out_q.size() != start || wb_cnt != wb0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s abort: got %0d bytes/%0d wb_done/out_valid=%b, required 0/0/0",
                         name, out_q.size() - start, wb_cnt - wb0, out_valid);
            end
            return;
        end

        tests++;
        if (res_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s send_entry: got res_ready=%b out_valid=%b, required 0 1", name, res_ready, out_valid);
        end
        host_mat_wb = 1'b0;   // must not disturb an ongoing transmission

        guard = 0;
        while (wb_cnt == wb0 && guard < 100) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = tog; tog = ~tog; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    fails++;
                    $display("FAIL %s stall_hold: got valid=%b data=%h, required 1 %h", name, out_valid, out_data, prev_data);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        tests++;
        if (guard >= 100) begin
            fails++;
            $display("FAIL %s send_timeout: got %0d bytes, no wb_done", name, out_q.size() - start);
        end
        repeat (3) @(posedge clk);
        #1;

        for (int r = 0; r < N_RES; r++) begin
            for (int k = 0; k < BPR; k++) begin
                b = 8'((res[r] >> (8 * k)) & 16'h00FF);
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
`ifdef CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        tests++;
        if (out_q.size() - start != exp_q.size()) begin
            fails++;
            $display("FAIL %s byte_count: got %0d, required %0d", name, out_q.size() - start, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && start + i < out_q.size(); i++) begin
            tests++;
            if (out_q[start + i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s byte%0d: got %h, required %h", name, i, out_q[start + i], exp_q[i]);
            end
        end
        tests++;
        if (wb_cnt - wb0 != 1) begin
            fails++;
            $display("FAIL %s wb_done: got %0d pulses, required 1", name, wb_cnt - wb0);
        end
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({in_ready, mat_data, mat_valid, mat_idx, load_done, res_ready, out_data, out_valid, wb_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {in_ready, mat_data, mat_valid, mat_idx, load_done, res_ready, out_data, out_valid, wb_done});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({in_ready, mat_valid, res_ready, out_valid, wb_done, load_done} !== '0) begin
            fails++;
            $display("FAIL idle_outputs: got %b, required 0",
                     {in_ready, mat_valid, res_ready, out_valid, wb_done, load_done});
        end
    endtask

    task automatic test_reset_mid_load;
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        drive_load(b, 3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, mat_data, mat_valid, mat_idx, load_done, res_ready, out_data, out_valid, wb_done} !== '0) begin
            fails++;
            $display("FAIL midload_reset: got %h, required 0",
                     {in_ready, mat_data, mat_valid, mat_idx, load_done, res_ready, out_data, out_valid, wb_done});
        end
        host_req_mat = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        check_load(b, N_ELEMS, 1'b0, "post_reset_load");
    endtask

    task automatic test_load_directed;
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = 8'(8'h11 * (i + 1));
        host_req_mat = 1'b1;
        in_valid     = 1'b1;
        in_data      = b[0];
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_in_ready: got %b, required 0", in_ready);
        end
        check_load(b, N_ELEMS, 1'b1, "load_directed");
    endtask

    task automatic test_load_random;
        logic [7:0] b [8];
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
            check_load(b, N_ELEMS, 1'b0, "load_random");
        end
    endtask

    task automatic test_load_abort;
        logic [7:0] b [8];
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        check_load(b, 5, 1'b0, "load_abort");
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        check_load(b, N_ELEMS, 1'b1, "load_after_abort");
    endtask

    task automatic test_writeback;
        logic [15:0] r [4];
        r[0] = 16'h1234; r[1] = 16'h5678; r[2] = 16'h9ABC; r[3] = 16'hDEF0;
        check_wb(r, N_RES, 0, 1'b0, "wb_directed");
        check_wb(r, N_RES, 1, 1'b0, "wb_toggle");
    endtask

    task automatic test_writeback_random;
        logic [15:0] r [4];
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
            check_wb(r, N_RES, 2, 1'b1, "wb_random");
        end
    endtask

    task automatic test_writeback_abort;
        logic [15:0] r [4];
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
        check_wb(r, 2, 0, 1'b0, "wb_abort");
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
        check_wb(r, N_RES, 2, 1'b1, "wb_after_abort");
    endtask

    task automatic test_both_high;
        logic [7:0]  b [8];
        logic [15:0] r [4];
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
        host_req_mat = 1'b1;
        host_mat_wb  = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || res_ready !== 1'b0) begin
            fails++;
            $display("FAIL both_high_priority: got in_ready=%b res_ready=%b, required 1 0", in_ready, res_ready);
        end
        check_load(b, N_ELEMS, 1'b1, "both_load");
        check_wb(r, N_RES, 0, 1'b0, "both_wb");
    endtask

    initial begin
        test_reset;
        test_reset_mid_load;
        test_load_directed;
        test_load_random;
        test_load_abort;
        test_writeback;
        test_writeback_random;
        test_writeback_abort;
        test_both_high;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
